data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter WIDTH, default 32, data and address width.
REQ-002 Parameter SETS, default 64, number of direct-mapped lines (power of two).
REQ-003 Parameter LINE_WORDS, default 4, words per line (power of two, >=2).
REQ-004 The block SHALL expose these ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU memory-stage request present.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  WIDTH  byte address; bits [1:0] ignored.
- req_wdata  in  WIDTH  store data.
- req_wstrb  in  4  store byte enables.
- stall  out  1  cache busy; CPU holds its request.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  WIDTH  load data, valid with resp_valid.
- mem_req_valid  out  1  backing-memory request.
- mem_req_write  out  1  backing-memory store.
- mem_req_addr  out  WIDTH  word-aligned backing address.
- mem_req_wdata  out  WIDTH  backing store data.
- mem_req_wstrb  out  4  backing byte enables.
- mem_req_ready  in  1  backing memory accepts request this cycle.
- mem_resp_valid  in  1  backing read data valid.
- mem_resp_rdata  in  WIDTH  backing read data.

Function
REQ-005 Address split SHALL be offset = log2(LINE_WORDS*4) LSBs, index = next log2(SETS) bits, tag = remaining MSBs.
REQ-006 FSM states SHALL be IDLE, COMPARE, REFILL_REQ, REFILL_WAIT, WT_REQ; stall SHALL be 1 in every state except IDLE.
REQ-007 IDLE: req_valid=1 SHALL register the request and go to COMPARE next cycle.
REQ-008 COMPARE, load hit (valid and tag match): resp_valid=1 with the selected word, next state IDLE; load latency is 1 cycle after acceptance.
REQ-009 COMPARE, load miss: beat counter cleared, next state REFILL_REQ.
REQ-010 REFILL_REQ: mem_req_valid=1, mem_req_write=0, mem_req_addr = line base + 4*beat; on mem_req_ready go to REFILL_WAIT.
REQ-011 REFILL_WAIT: on mem_resp_valid write the word into the line at the current beat; if beat = LINE_WORDS-1, set valid and tag and return to COMPARE (replay produces the hit response); otherwise increment beat and return to REFILL_REQ.
REQ-012 COMPARE, store: write-through, no-write-allocate; on hit, merge req_wdata into the cached word per req_wstrb; hit or miss, go to WT_REQ with the line state otherwise unchanged.
REQ-013 WT_REQ: mem_req_valid=1, mem_req_write=1, the registered address, data and strobes; on mem_req_ready pulse resp_valid (resp_rdata = 0) and go to IDLE.
REQ-014 mem_req_valid and all mem_req_* fields SHALL hold stable until mem_req_ready is sampled high.
REQ-015 mem_resp_valid outside REFILL_WAIT SHALL be ignored.
REQ-016 req_valid while stall=1 SHALL be ignored (the CPU re-presents the request).
REQ-017 A miss on a valid line with a different tag SHALL overwrite that line (eviction without writeback).

Reset
REQ-018 On rst: state IDLE; all valid bits 0; beat 0; stall, resp_valid and mem_req_valid 0 on the following cycle; all other outputs 0.
REQ-019 rst during a refill or write-through SHALL abandon the transaction; the partially filled line SHALL remain invalid; a later stray mem_resp_valid SHALL be ignored.
REQ-020 Data and tag arrays are not reset.

Configuration
REQ-021 With macro CACHE_STATS_EN defined, the block SHALL add outputs hit_count and miss_count (32-bit, reset to 0, saturating), counting COMPARE loads as hit or miss and excluding post-refill replays; without the macro these ports and counters SHALL be absent.

Verification
REQ-022 After reset, load 0x100 with backing words 0x11/0x22/0x33/0x44 at 0x100..0x10C -> four reads issued in address order, then resp_rdata=0x11; next load 0x108 -> resp 0x33 one cycle after acceptance, no mem request.
REQ-023 Load 0x100, then 0x500 (same index 16) -> second load misses and refills; re-load 0x100 misses again.
REQ-024 With the 0x100 line loaded, store 0xAB to 0x104 with wstrb=0001 -> one mem write at 0x104 with strobe 0001; load 0x104 -> 0x000000AB with no refill.
REQ-025 Store to uncached 0x2000 -> exactly one mem write, no refill; load 0x2000 -> miss.
REQ-026 rst asserted in REFILL_WAIT at beat 2 -> next cycle stall=0 and mem_req_valid=0; load 0x100 -> full 4-beat refill.
REQ-027 CACHE_STATS_EN defined, scenario REQ-022 -> hit_count=1, miss_count=1.

Source files
------------

// File: rtl/data_cache.sv
// Direct-mapped, write-through / no-write-allocate data cache with a single
// outstanding backing-memory request. Loads that miss refill the whole line
// one word per request, then replay through COMPARE to produce the response.
// Optional build macro CACHE_STATS_EN adds saturating hit_count / miss_count
// outputs.
module data_cache #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned SETS       = 64,
   parameter int unsigned LINE_WORDS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   input  logic             req_write,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   input  logic [3:0]       req_wstrb,
   output logic             stall,
   output logic             resp_valid,
   output logic [WIDTH-1:0] resp_rdata,
   output logic             mem_req_valid,
   output logic             mem_req_write,
   output logic [WIDTH-1:0] mem_req_addr,
   output logic [WIDTH-1:0] mem_req_wdata,
   output logic [3:0]       mem_req_wstrb,
   input  logic             mem_req_ready,
   input  logic             mem_resp_valid,
`ifdef CACHE_STATS_EN
   output logic [31:0]      hit_count,
   output logic [31:0]      miss_count,
`endif
   input  logic [WIDTH-1:0] mem_resp_rdata
);

   localparam int unsigned WORD_W  = $clog2(LINE_WORDS);
   localparam int unsigned IDX_W   = $clog2(SETS);
   localparam int unsigned WADDR_W = WIDTH - 2;
   localparam int unsigned TAG_W   = WADDR_W - WORD_W - IDX_W;

   typedef enum logic [2:0] {
      IDLE,
      COMPARE,
      REFILL_REQ,
      REFILL_WAIT,
      WT_REQ
   } state_t;

   state_t              state;
   logic [SETS-1:0]     valid;
   logic [TAG_W-1:0]    tag_mem  [SETS];
   logic [WIDTH-1:0]    data_mem [SETS][LINE_WORDS];

   // Captured CPU request; the word address drops the ignored byte bits
   logic [WADDR_W-1:0]  cur_waddr;
   logic                cur_write;
   logic [WIDTH-1:0]    cur_wdata;
   logic [3:0]          cur_wstrb;
   logic [WORD_W-1:0]   beat;
   logic                replay;

   logic [WORD_W-1:0]   cur_word;
   logic [IDX_W-1:0]    cur_idx;
   logic [TAG_W-1:0]    cur_tag;
   logic                hit;
   logic [WIDTH-1:0]    hit_word;
   logic [WIDTH-1:0]    merged;
   logic [WORD_W-1:0]   next_beat;
   logic                unused_addr_bits;

   assign unused_addr_bits = ^req_addr[1:0];

   assign cur_word  = cur_waddr[WORD_W-1:0];
   assign cur_idx   = cur_waddr[WORD_W +: IDX_W];
   assign cur_tag   = cur_waddr[WADDR_W-1 -: TAG_W];
   assign hit       = valid[cur_idx] && (tag_mem[cur_idx] == cur_tag);
   assign hit_word  = data_mem[cur_idx][cur_word];
   assign next_beat = beat + WORD_W'(1);

   // Byte-merge the store data into the currently cached word
   always_comb begin
      merged = hit_word;
      for (int b = 0; b < 4; b++) begin
         if (cur_wstrb[b]) merged[8*b +: 8] = cur_wdata[8*b +: 8];
      end
   end

   // Controller: request capture, lookup, line refill and write-through
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         valid         <= '0;
         beat          <= '0;
         replay        <= 1'b0;
         cur_waddr     <= '0;
         cur_write     <= 1'b0;
         cur_wdata     <= '0;
         cur_wstrb     <= '0;
         stall         <= 1'b0;
         resp_valid    <= 1'b0;
         resp_rdata    <= '0;
         mem_req_valid <= 1'b0;
         mem_req_write <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wdata <= '0;
         mem_req_wstrb <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  cur_waddr <= req_addr[WIDTH-1:2];
                  cur_write <= req_write;
                  cur_wdata <= req_wdata;
                  cur_wstrb <= req_wstrb;
                  replay    <= 1'b0;
                  stall     <= 1'b1;
                  state     <= COMPARE;
               end
            end
            COMPARE: begin
               if (cur_write) begin
                  if (hit) data_mem[cur_idx][cur_word] <= merged;
                  mem_req_valid <= 1'b1;
                  mem_req_write <= 1'b1;
                  mem_req_addr  <= {cur_waddr, 2'b00};
                  mem_req_wdata <= cur_wdata;
                  mem_req_wstrb <= cur_wstrb;
                  state         <= WT_REQ;
               end else if (hit) begin
                  resp_valid <= 1'b1;
                  resp_rdata <= hit_word;
                  stall      <= 1'b0;
                  state      <= IDLE;
               end else begin
                  beat          <= '0;
                  mem_req_valid <= 1'b1;
                  mem_req_write <= 1'b0;
                  mem_req_addr  <= {cur_waddr[WADDR_W-1:WORD_W], WORD_W'(0), 2'b00};
                  mem_req_wdata <= '0;
                  mem_req_wstrb <= '0;
                  state         <= REFILL_REQ;
               end
            end
            REFILL_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= REFILL_WAIT;
               end
            end
            REFILL_WAIT: begin
               if (mem_resp_valid) begin
                  data_mem[cur_idx][beat] <= mem_resp_rdata;
                  if (beat == WORD_W'(LINE_WORDS - 1)) begin
                     valid[cur_idx]   <= 1'b1;
                     tag_mem[cur_idx] <= cur_tag;
                     replay           <= 1'b1;
                     state            <= COMPARE;
                  end else begin
                     beat          <= next_beat;
                     mem_req_valid <= 1'b1;
                     mem_req_addr  <= {cur_waddr[WADDR_W-1:WORD_W], next_beat, 2'b00};
                     state         <= REFILL_REQ;
                  end
               end
            end
            WT_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  resp_valid    <= 1'b1;
                  resp_rdata    <= '0;
                  stall         <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CACHE_STATS_EN
   // First-pass load lookups only; the replay after a refill is not counted
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (state == COMPARE && !cur_write && !replay) begin
         if (hit) begin
            if (hit_count != '1) hit_count <= hit_count + 32'd1;
         end else begin
            if (miss_count != '1) miss_count <= miss_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios then randomized
// loads/stores against a tag-level cache model and a flat memory model.
`timescale 1ns/1ps
module tb_data_cache;

   localparam int unsigned LW = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        stall, resp_valid;
   logic [31:0] resp_rdata;
   logic        mem_req_valid, mem_req_write;
   logic [31:0] mem_req_addr, mem_req_wdata;
   logic [3:0]  mem_req_wstrb;
   logic        mem_req_ready, mem_resp_valid;
   logic [31:0] mem_resp_rdata;
`ifdef CACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   data_cache dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_write      (req_write),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .req_wstrb      (req_wstrb),
      .stall          (stall),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .mem_req_valid  (mem_req_valid),
      .mem_req_write  (mem_req_write),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wdata  (mem_req_wdata),
      .mem_req_wstrb  (mem_req_wstrb),
      .mem_req_ready  (mem_req_ready),
      .mem_resp_valid (mem_resp_valid),
`ifdef CACHE_STATS_EN
      .hit_count      (hit_count),
      .miss_count     (miss_count),
`endif
      .mem_resp_rdata (mem_resp_rdata)
   );

   // Backing memory (written by the DUT) and expected memory (written by the bench)
   logic [31:0] bmem    [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] rd_log[$];
   logic [31:0] wr_addr_log[$];
   logic [31:0] wr_data_log[$];
   logic [3:0]  wr_strb_log[$];

   // Cache model: which tag each set currently holds
   bit          mvalid [64];
   logic [31:0] mtag   [64];
   int unsigned hit_cnt  = 0;
   int unsigned miss_cnt = 0;

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] bmem_rd(input logic [31:0] a);
      return bmem.exists(a) ? bmem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
      hit_cnt  = 0;
      miss_count_reset: miss_cnt = 0;
   endtask

   task automatic check_stats(input string tag);
`ifdef CACHE_STATS_EN
      check({tag, "_hit_count"},  hit_count,  32'(hit_cnt));
      check({tag, "_miss_count"}, miss_count, 32'(miss_cnt));
`else
      if (tag.len() == 0) $display("empty stats tag");
`endif
   endtask

   // One CPU access; garbage is presented with req_valid=1 while stalled
   task automatic do_access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] ws, input string tag);
      int          idx;
      logic [31:0] tg, base, wa;
      bit          hit;
      int          k;
      idx  = int'((addr >> 4) & 32'h3F);
      tg   = addr >> 10;
      base = addr & ~32'hF;
      wa   = addr & ~32'h3;
      hit  = mvalid[idx] && (mtag[idx] == tg);
      k = 0;
      while (stall !== 1'b0 && k < 200) begin @(negedge clk); k++; end
      rd_log.delete();
      wr_addr_log.delete();
      wr_data_log.delete();
      wr_strb_log.delete();
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      req_wstrb = ws;
      @(negedge clk);
      req_write = $urandom_range(0, 1) == 1;
      req_addr  = $urandom();
      req_wdata = $urandom();
      req_wstrb = 4'($urandom_range(0, 15));
      k = 1;
      while (resp_valid !== 1'b1 && k < 400) begin @(negedge clk); k++; end
      req_valid = 1'b0;
      check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
      if (wr) begin
         check({tag, "_st_rdata"}, resp_rdata, 32'd0);
         check({tag, "_st_reads"}, 32'(rd_log.size()), 32'd0);
         check({tag, "_st_writes"}, 32'(wr_addr_log.size()), 32'd1);
         if (wr_addr_log.size() >= 1) begin
            check({tag, "_wr_addr"}, wr_addr_log[0], wa);
            check({tag, "_wr_data"}, wr_data_log[0], wd);
            check({tag, "_wr_strb"}, 32'(wr_strb_log[0]), 32'(ws));
         end
         ref_mem[wa] = merge(ref_rd(wa), wd, ws);
      end else begin
         check({tag, "_ld_rdata"}, resp_rdata, ref_rd(wa));
         check({tag, "_ld_reads"}, 32'(rd_log.size()), hit ? 32'd0 : 32'(LW));
         for (int i = 0; i < rd_log.size() && i < int'(LW); i++)
            check({tag, "_rd_addr"}, rd_log[i], base + 32'(4 * i));
         check({tag, "_ld_writes"}, 32'(wr_addr_log.size()), 32'd0);
         if (hit) begin
            check({tag, "_hit_latency"}, 32'(k), 32'd2);
            hit_cnt++;
         end else begin
            mvalid[idx] = 1'b1;
            mtag[idx]   = tg;
            miss_cnt++;
         end
      end
   endtask

   // Backing memory: random ready, one read in flight, 2..4 cycle read latency
   initial begin : responder
      bit          pend = 1'b0;
      int          pend_cnt = 0;
      logic [31:0] pend_addr = '0;
      bit          held = 1'b0;
      logic        h_write = 1'b0;
      logic [31:0] h_addr = '0, h_data = '0;
      logic [3:0]  h_strb = '0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = '0;
      forever begin
         @(negedge clk);
         mem_req_ready  = 1'b0;
         mem_resp_valid = 1'b0;
         if (held && rst === 1'b0) begin
            check("mem_hold_valid", 32'(mem_req_valid), 32'd1);
            check("mem_hold_write", 32'(mem_req_write), 32'(h_write));
            check("mem_hold_addr",  mem_req_addr,  h_addr);
            check("mem_hold_wdata", mem_req_wdata, h_data);
            check("mem_hold_wstrb", 32'(mem_req_wstrb), 32'(h_strb));
         end
         held = 1'b0;
         if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               mem_resp_valid = 1'b1;
               mem_resp_rdata = bmem_rd(pend_addr);
               pend = 1'b0;
            end
         end
         if (mem_req_valid === 1'b1 && rst === 1'b0) begin
            if (!pend && $urandom_range(0, 1) == 1) begin
               mem_req_ready = 1'b1;
               if (mem_req_write) begin
                  wr_addr_log.push_back(mem_req_addr);
                  wr_data_log.push_back(mem_req_wdata);
                  wr_strb_log.push_back(mem_req_wstrb);
                  bmem[mem_req_addr] = merge(bmem_rd(mem_req_addr), mem_req_wdata, mem_req_wstrb);
               end else begin
                  rd_log.push_back(mem_req_addr);
                  pend      = 1'b1;
                  pend_cnt  = $urandom_range(2, 4);
                  pend_addr = mem_req_addr;
               end
            end else begin
               held    = 1'b1;
               h_write = mem_req_write;
               h_addr  = mem_req_addr;
               h_data  = mem_req_wdata;
               h_strb  = mem_req_wstrb;
            end
         end
      end
   end

   initial begin : watchdog
      #5ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation time limit");
   end

   initial begin : stimulus
      int          k;
      logic [31:0] a;
      int          idx_pool [3] = '{16, 17, 5};
      rst       = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_wstrb = '0;
      clear_model();
      repeat (3) @(negedge clk);
      check("rst_stall",         32'(stall),         32'd0);
      check("rst_resp_valid",    32'(resp_valid),    32'd0);
      check("rst_resp_rdata",    resp_rdata,         32'd0);
      check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
      check("rst_mem_req_addr",  mem_req_addr,       32'd0);
      check_stats("rst");
      rst = 1'b0;
      @(negedge clk);

      // Line 0x100 with known contents: refill in order, then hit on 0x108
      for (int i = 0; i < 4; i++) begin
         bmem[32'h100 + 32'(4 * i)]    = 32'h11 * 32'(i + 1);
         ref_mem[32'h100 + 32'(4 * i)] = 32'h11 * 32'(i + 1);
      end
      do_access(1'b0, 32'h100, '0, '0, "ld100");
      check("ld100_value", resp_rdata, 32'h11);
      do_access(1'b0, 32'h108, '0, '0, "ld108");
      check("ld108_value", resp_rdata, 32'h33);
`ifdef CACHE_STATS_EN
      check("stats_hit_after_first_pair",  hit_count,  32'd1);
      check("stats_miss_after_first_pair", miss_count, 32'd1);
`endif

      // Conflict in set 16 evicts, then 0x100 misses again
      do_access(1'b0, 32'h500, '0, '0, "ld500");
      do_access(1'b0, 32'h100, '0, '0, "ld100_again");

      // Store hit with a single byte enable, then read it back from the cache
      do_access(1'b1, 32'h104, 32'h0000_00AB, 4'b0001, "st104");
      do_access(1'b0, 32'h104, '0, '0, "ld104");
      check("ld104_value", resp_rdata, 32'h0000_00AB);

      // Store miss does not allocate
      do_access(1'b1, 32'h2000, 32'hCAFE_F00D, 4'b1111, "st2000");
      do_access(1'b0, 32'h2000, '0, '0, "ld2000");
      check_stats("directed");

      // Reset while waiting for refill beat 2 of a different line
      while (stall !== 1'b0) @(negedge clk);
      rd_log.delete();
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'h900;
      @(negedge clk);
      req_valid = 1'b0;
      k = 0;
      while (!(rd_log.size() == 3 && mem_req_valid === 1'b0) && k < 300) begin
         @(negedge clk);
         k++;
      end
      check("rst_reach_beat2", 32'(rd_log.size()), 32'd3);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_stall",         32'(stall),         32'd0);
      check("midrst_mem_req_valid", 32'(mem_req_valid), 32'd0);
      check("midrst_resp_valid",    32'(resp_valid),    32'd0);
      rst = 1'b0;
      clear_model();
      check_stats("midrst");
      do_access(1'b0, 32'h100, '0, '0, "ld100_after_rst");
      do_access(1'b0, 32'h900, '0, '0, "ld900_after_rst");

      // Random loads/stores over a few sets and tags
      for (int n = 0; n < 150; n++) begin
         a = ($urandom_range(0, 3) << 10) | (32'(idx_pool[$urandom_range(0, 2)]) << 4)
           | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
         do_access($urandom_range(0, 9) < 4, a, $urandom(), 4'($urandom_range(0, 15)), "rnd");
      end
      check_stats("final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
